// File: rtl/onfi_cmd_seq.sv
// rtl/onfi_cmd_seq.sv - ONFI single-operation command/address/wait/data sequencer
module onfi_cmd_seq #(
  parameter int LEN_W   = 12,
  parameter int WB_CYC  = 8,
  parameter int TMO_CYC = 65535
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       cmd1_i,
  input  logic             cmd2_en_i,
  input  logic [7:0]       cmd2_i,
  input  logic [2:0]       naddr_i,
  input  logic [39:0]      addr_i,
  input  logic             dir_i,
  input  logic [LEN_W-1:0] nbytes_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tmo_o,
  output logic             phy_valid_o,
  output logic [1:0]       phy_op_o,
  output logic [7:0]       phy_byte_o,
  input  logic             phy_ready_i,
  input  logic [7:0]       phy_rdata_i,
  input  logic             phy_rvalid_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rb_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_WAIT, S_DATA, S_DONE
  } state_t;

  localparam logic [1:0]  OP_CMD  = 2'd0;
  localparam logic [1:0]  OP_ADDR = 2'd1;
  localparam logic [1:0]  OP_DIN  = 2'd2;
  localparam logic [1:0]  OP_DOUT = 2'd3;
  localparam logic [15:0] WB_LIM  = 16'(WB_CYC);
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

  state_t           state, state_nx;
  logic [7:0]       cmd1_q, cmd2_q;
  logic             cmd2_en_q, dir_q;
  logic [2:0]       addr_left;
  logic [39:0]      addr_sh;
  logic [LEN_W-1:0] byte_cnt;
  logic [15:0]      wait_cnt;
  logic             rd_pend;
  logic             rb_meta, rb_sync;
  logic             tmo_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;

  logic             has_data, last_byte, rb_ok, tmo_hit, data_beat, accept;
  state_t           after_addr, after_wait, after_data;

  assign has_data  = (byte_cnt != '0);
  assign last_byte = (byte_cnt == LEN_W'(1));
  assign rb_ok     = (wait_cnt >= WB_LIM) && rb_sync;
  assign tmo_hit   = (state == S_WAIT) && !rb_ok && (wait_cnt == TMO_LIM);
  assign accept    = phy_valid_o && phy_ready_i;
  assign data_beat = (state == S_DATA) &&
                     (dir_q ? (rd_pend && phy_rvalid_i) : (wr_valid_i && phy_ready_i));

  // Reads put the busy wait before the data, writes put it after the data.
  assign after_addr = dir_q ? (cmd2_en_q ? S_CMD2 : (has_data ? S_DATA : S_DONE))
                            : (has_data ? S_DATA : (cmd2_en_q ? S_CMD2 : S_DONE));
  assign after_wait = (dir_q && has_data) ? S_DATA : S_DONE;
  assign after_data = (!dir_q && cmd2_en_q) ? S_CMD2 : S_DONE;

  assign busy_o     = (state != S_IDLE);
  assign tmo_o      = tmo_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

  // State register.
  always_ff @(posedge sysclk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Operation latches, counters, R/B# synchroniser and read-return capture.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      cmd1_q     <= 8'd0;
      cmd2_q     <= 8'd0;
      cmd2_en_q  <= 1'b0;
      dir_q      <= 1'b0;
      addr_left  <= 3'd0;
      addr_sh    <= 40'd0;
      byte_cnt   <= '0;
      wait_cnt   <= 16'd0;
      rd_pend    <= 1'b0;
      rb_meta    <= 1'b0;
      rb_sync    <= 1'b0;
      tmo_q      <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rb_meta    <= rb_i;
      rb_sync    <= rb_meta;
      rd_valid_q <= 1'b0;
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + 16'd1 : 16'd0;
      if (state == S_IDLE && start_i) begin
        cmd1_q    <= cmd1_i;
        cmd2_q    <= cmd2_i;
        cmd2_en_q <= cmd2_en_i;
        dir_q     <= dir_i;
        addr_left <= (naddr_i > 3'd5) ? 3'd5 : naddr_i;
        addr_sh   <= addr_i;
        byte_cnt  <= nbytes_i;
        rd_pend   <= 1'b0;
        tmo_q     <= 1'b0;
      end
      if (state == S_ADDR && accept) begin
        addr_sh   <= {8'd0, addr_sh[39:8]};
        addr_left <= addr_left - 3'd1;
      end
      if (tmo_hit) tmo_q <= 1'b1;
      if (state == S_DATA && dir_q) begin
        if (accept) rd_pend <= 1'b1;
        if (rd_pend && phy_rvalid_i) begin
          rd_pend    <= 1'b0;
          rd_data_q  <= phy_rdata_i;
          rd_valid_q <= 1'b1;
        end
      end
      if (data_beat) byte_cnt <= byte_cnt - LEN_W'(1);
    end
  end

  // Next state and phy/stream handshake outputs.
  always_comb begin
    state_nx    = state;
    phy_valid_o = 1'b0;
    phy_op_o    = OP_CMD;
    phy_byte_o  = 8'd0;
    wr_ready_o  = 1'b0;
    done_o      = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nx = S_CMD1;
      S_CMD1: begin
        phy_valid_o = 1'b1;
        phy_byte_o  = cmd1_q;
        if (phy_ready_i) state_nx = (addr_left != 3'd0) ? S_ADDR : after_addr;
      end
      S_ADDR: begin
        phy_valid_o = 1'b1;
        phy_op_o    = OP_ADDR;
        phy_byte_o  = addr_sh[7:0];
        if (phy_ready_i && addr_left == 3'd1) state_nx = after_addr;
      end
      S_CMD2: begin
        phy_valid_o = 1'b1;
        phy_byte_o  = cmd2_q;
        if (phy_ready_i) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (rb_ok)        state_nx = after_wait;
        else if (tmo_hit) state_nx = S_DONE;
      end
      S_DATA: begin
        if (dir_q) begin
          phy_valid_o = !rd_pend;
          phy_op_o    = OP_DOUT;
        end else begin
          phy_valid_o = wr_valid_i;
          phy_op_o    = OP_DIN;
          phy_byte_o  = wr_data_i;
          wr_ready_o  = phy_ready_i;
        end
        if (data_beat && last_byte) state_nx = after_data;
      end
      S_DONE: begin
        done_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_onfi_cmd_seq.sv
// tb/tb_onfi_cmd_seq.sv - randomized self-checking bench for onfi_cmd_seq
module tb_onfi_cmd_seq;
  localparam int LEN_W   = 12;
  localparam int WB_CYC  = 8;
  localparam int TMO_CYC = 100;
  localparam int STUCK   = 1000000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [7:0]       cmd1_i = 8'd0, cmd2_i = 8'd0;
  logic             cmd2_en_i = 1'b0, dir_i = 1'b0;
  logic [2:0]       naddr_i = 3'd0;
  logic [39:0]      addr_i = 40'd0;
  logic [LEN_W-1:0] nbytes_i = '0;
  logic             busy_o, done_o, tmo_o, phy_valid_o, wr_ready_o, rd_valid_o;
  logic [1:0]       phy_op_o;
  logic [7:0]       phy_byte_o, rd_data_o;
  logic             phy_ready_i = 1'b0, phy_rvalid_i = 1'b0, wr_valid_i = 1'b0, rb_i = 1'b1;
  logic [7:0]       phy_rdata_i = 8'd0, wr_data_i = 8'd0;

  onfi_cmd_seq #(.LEN_W(LEN_W), .WB_CYC(WB_CYC), .TMO_CYC(TMO_CYC)) dut (
    .sysclk(clk), .rst_n(rst_n), .start_i(start_i), .cmd1_i(cmd1_i),
    .cmd2_en_i(cmd2_en_i), .cmd2_i(cmd2_i), .naddr_i(naddr_i), .addr_i(addr_i),
    .dir_i(dir_i), .nbytes_i(nbytes_i), .busy_o(busy_o), .done_o(done_o),
    .tmo_o(tmo_o), .phy_valid_o(phy_valid_o), .phy_op_o(phy_op_o),
    .phy_byte_o(phy_byte_o), .phy_ready_i(phy_ready_i), .phy_rdata_i(phy_rdata_i),
    .phy_rvalid_i(phy_rvalid_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rb_i(rb_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shared model state: accepted phy ops as {op, byte}, byte zeroed for DOUT.
  logic [9:0] got_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_bytes[64];
  int wr_idx = 0, rd_cnt = 0, done_cnt = 0, dout_cd = 0;
  int cmd_seen = 0, cmd2_cyc = -1, first_data_cyc = -1, tmo_cyc = -1;
  int rb_delay = 0, rb_release = 0, ready_mode = 0, stall_ctr = 0, stall_bad = 0;
  int last_done_cyc = 0, prev_done_cyc = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_op = 2'd0;
  logic [7:0] prev_byte = 8'd0;

  // Phy, write-stream and NAND R/B# behaviour plus the output monitor.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: phy_ready_i = 1'b1;
        1: phy_ready_i = 1'($urandom_range(0, 1));
        default: phy_ready_i = (stall_ctr >= 2);
      endcase
      phy_rvalid_i = 1'b0;
      if (dout_cd > 0) begin
        dout_cd--;
        if (dout_cd == 0) begin
          phy_rvalid_i = 1'b1;
          phy_rdata_i  = 8'($urandom);
          exp_rd.push_back(phy_rdata_i);
        end
      end
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_data_i  = wr_bytes[wr_idx];
      rb_i       = (cyc >= rb_release);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
        dout_cd    = 0;
      end else begin
        if (rd_valid_o) begin
          rd_cnt++;
          if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
          else                    check("rd_data", rd_data_o, exp_rd.pop_front());
        end
        if (done_o) begin
          done_cnt++;
          prev_done_cyc = last_done_cyc;
          last_done_cyc = cyc;
        end
        if (tmo_o && tmo_cyc < 0) tmo_cyc = cyc;
        if (prev_stall && !(phy_valid_o && phy_op_o == prev_op && phy_byte_o == prev_byte))
          stall_bad++;
        if (phy_valid_o && phy_ready_i) begin
          got_q.push_back({phy_op_o, (phy_op_o == 2'd3) ? 8'd0 : phy_byte_o});
          if (phy_op_o == 2'd0) begin
            cmd_seen++;
            if (cmd_seen == 2) begin
              cmd2_cyc   = cyc;
              rb_release = cyc + 1 + rb_delay;
            end
          end
          if (phy_op_o[1] && first_data_cyc < 0) first_data_cyc = cyc;
          if (phy_op_o == 2'd3) dout_cd = $urandom_range(1, 3);
          if (phy_op_o == 2'd2 && wr_idx < 63) wr_idx++;
          stall_ctr = 0;
        end else if (phy_valid_o) begin
          stall_ctr++;
        end
        prev_stall = phy_valid_o && !phy_ready_i && phy_op_o != 2'd2;
        prev_op    = phy_op_o;
        prev_byte  = phy_byte_o;
      end
    end
  end

  task automatic prep_op(input int rbd, input int rmode);
    got_q.delete();
    exp_rd.delete();
    rd_cnt = 0; cmd_seen = 0; cmd2_cyc = -1; first_data_cyc = -1; tmo_cyc = -1;
    wr_idx = 0; stall_bad = 0; stall_ctr = 0; rb_release = 0;
    rb_delay = rbd; ready_mode = rmode;
    foreach (wr_bytes[i]) wr_bytes[i] = 8'($urandom);
  endtask

  task automatic scramble_inputs();
    start_i   = 1'($urandom_range(0, 1));
    cmd1_i    = 8'($urandom);
    cmd2_i    = 8'($urandom);
    cmd2_en_i = 1'($urandom_range(0, 1));
    dir_i     = 1'($urandom_range(0, 1));
    naddr_i   = 3'($urandom);
    addr_i    = {8'($urandom), 32'($urandom)};
    nbytes_i  = LEN_W'($urandom_range(0, 20));
  endtask

  task automatic run_op(input string name, input logic [7:0] c1, input logic c2en,
                        input logic [7:0] c2, input logic [2:0] na, input logic [39:0] ad,
                        input logic d, input int nb, input int rbd, input int rmode);
    logic [9:0] exp_q[$];
    int d0, na_eff;
    logic tmo_exp, seen;
    @(negedge clk);
    prep_op(rbd, rmode);
    d0 = done_cnt;
    cmd1_i = c1; cmd2_en_i = c2en; cmd2_i = c2; naddr_i = na; addr_i = ad;
    dir_i = d; nbytes_i = LEN_W'(nb); start_i = 1'b1;
    @(negedge clk);
    #2;
    check({name, "_busy_first"}, busy_o, 1);
    check({name, "_cmd1_first"}, {phy_valid_o, phy_op_o, phy_byte_o}, {1'b1, 2'd0, c1});
    check({name, "_tmo_cleared"}, tmo_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      scramble_inputs();
      #2;
      if (done_cnt != d0) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check({name, "_one_done"}, done_cnt - d0, 1);
    check({name, "_idle_after"}, busy_o, 0);

    tmo_exp = c2en && (rbd >= STUCK);
    na_eff  = (na > 3'd5) ? 5 : int'(na);
    exp_q.push_back({2'd0, c1});
    for (int i = 0; i < na_eff; i++) exp_q.push_back({2'd1, 8'(ad >> (8 * i))});
    if (d) begin
      if (c2en) exp_q.push_back({2'd0, c2});
      if (!tmo_exp) for (int i = 0; i < nb; i++) exp_q.push_back({2'd3, 8'd0});
    end else begin
      for (int i = 0; i < nb; i++) exp_q.push_back({2'd2, wr_bytes[i]});
      if (c2en) exp_q.push_back({2'd0, c2});
    end
    check({name, "_op_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_op"}, got_q[i], exp_q[i]);
    check({name, "_rd_count"}, rd_cnt, (d && !tmo_exp) ? nb : 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_tmo"}, tmo_o, tmo_exp);
    check({name, "_stall_hold"}, stall_bad, 0);
    if (tmo_exp)
      check({name, "_tmo_time"}, (tmo_cyc - cmd2_cyc >= TMO_CYC) &&
                                  (tmo_cyc - cmd2_cyc <= TMO_CYC + WB_CYC + 4), 1);
    if (d && c2en && !tmo_exp && nb > 0) begin
      check({name, "_twb_gap"}, first_data_cyc - cmd2_cyc > WB_CYC, 1);
      if (rbd > WB_CYC + 3)
        check({name, "_rb_gate"}, first_data_cyc >= rb_release + 2, 1);
    end
  endtask

  initial begin
    int seen;
    int d0;
    foreach (wr_bytes[i]) wr_bytes[i] = 8'd0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_busy", busy_o, 0);
    check("reset_outs", {done_o, tmo_o, phy_valid_o, wr_ready_o, rd_valid_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("reset_idle", {busy_o, phy_valid_o}, 0);

    // Abort an operation while it is stalled in its address phase.
    prep_op(0, 2);
    cmd1_i = 8'h00; cmd2_en_i = 1'b1; cmd2_i = 8'h30; naddr_i = 3'd5;
    addr_i = 40'h0403020100; dir_i = 1'b1; nbytes_i = LEN_W'(4); start_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      #2;
      if (phy_valid_o && phy_op_o == 2'd1) seen = 1;
    end
    check("rst_mid_addr_reached", seen, 1);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_valid", phy_valid_o, 0);
    repeat (4) @(negedge clk);
    #2;
    check("rst_mid_no_done", done_cnt - d0, 0);

    run_op("page_read", 8'h00, 1'b1, 8'h30, 3'd5, 40'h0403020100, 1'b1, 4, 50, 0);
    run_op("program", 8'h80, 1'b1, 8'h10, 3'd2, 40'h00000000A5C3, 1'b0, 3, 20, 2);
    run_op("erase_tmo", 8'h60, 1'b1, 8'hD0, 3'd3, 40'h0000123456, 1'b0, 0, STUCK, 0);
    run_op("read_id", 8'h90, 1'b0, 8'h00, 3'd1, 40'h0, 1'b1, 5, 0, 1);
    run_op("addr_clamp", 8'h70, 1'b0, 8'h00, 3'd7, 40'hEEDDCCBBAA, 1'b1, 1, 0, 0);

    // start_i held high: back-to-back command-only operations.
    @(negedge clk);
    prep_op(0, 0);
    d0 = done_cnt;
    cmd1_i = 8'hFF; cmd2_en_i = 1'b0; naddr_i = 3'd0; dir_i = 1'b0;
    nbytes_i = '0; start_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt - d0 >= 2) seen = 1;
    end
    start_i = 1'b0;
    check("held_two_done", seen, 1);
    check("held_restart_gap", last_done_cyc - prev_done_cyc, 3);
    repeat (4) @(negedge clk);
    #2;
    check("held_ops", got_q.size() >= 2 && got_q[0] == {2'd0, 8'hFF} &&
                      got_q[1] == {2'd0, 8'hFF}, 1);
    check("held_idle", busy_o, 0);

    for (int n = 0; n < 25; n++) begin
      logic c2en, d;
      int rbd, nb;
      c2en = 1'($urandom_range(0, 1));
      d    = 1'($urandom_range(0, 1));
      nb   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      rbd  = (c2en && $urandom_range(0, 7) == 0) ? STUCK : $urandom_range(0, 60);
      run_op("rand", 8'($urandom), c2en, 8'($urandom), 3'($urandom), {8'($urandom), 32'($urandom)},
             d, nb, rbd, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
